// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the icache and dcache, with fixed dcache priority.
// Define MEMARB_RR_EN to alternate simultaneous requests between the two caches instead.
module mem_arbiter (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        ram_err
);

  localparam int unsigned WordW = 32;
  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [1:0] RamError  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2
  } state_t;

  state_t state;
  state_t nextState;
  logic   dReq;
  logic   ramDone;
  logic   ramFail;

  assign dReq    = dREN | dWEN;
  assign ramDone = (ramstate == RamAccess);
  assign ramFail = (ramstate == RamError);

  // Read data is shared; validity is qualified by the matching wait signal.
  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      ram_err <= 1'b0;
    end else begin
      state <= nextState;
      if ((state != IDLE) && ramFail) begin
        ram_err <= 1'b1;
      end
    end
  end

`ifdef MEMARB_RR_EN
  // Remembers which cache won the last grant; reset leaves the icache as last served.
  logic lastGrantD;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lastGrantD <= 1'b0;
    end else if (state == IDLE) begin
      if (nextState == DSERV) begin
        lastGrantD <= 1'b1;
      end else if (nextState == ISERV) begin
        lastGrantD <= 1'b0;
      end
    end
  end
`endif

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
`ifdef MEMARB_RR_EN
        if (dReq && iREN) begin
          nextState = lastGrantD ? ISERV : DSERV;
        end else if (dReq) begin
          nextState = DSERV;
        end else if (iREN) begin
          nextState = ISERV;
        end
`else
        if (dReq) begin
          nextState = DSERV;
        end else if (iREN) begin
          nextState = ISERV;
        end
`endif
      end
      // Word 0 of a block keeps the grant so the word 1 access follows directly.
      DSERV: begin
        if (!dReq || ramFail || (ramDone && daddr[2])) begin
          nextState = IDLE;
        end
      end
      ISERV: begin
        if (!iREN || ramFail || ramDone) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = WordW'(0);
    ramstore = WordW'(0);
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state)
      DSERV: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = ~ramDone;
      end
      ISERV: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = ~ramDone;
      end
      default: begin
      end
    endcase
  end

endmodule
